// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings and beat-count helper for the cpu memory controller
package mem_ctrl_pkg;

  localparam int ADDR_LEN     = 32;
  localparam int RAM_ADDR_LEN = 17;

  typedef enum logic [1:0] {
    MW_NONE = 2'd0,
    MW_BYTE = 2'd1,
    MW_HALF = 2'd2,
    MW_WORD = 2'd3
  } memw_type_e;

  typedef enum logic [1:0] {
    MC_IDLE   = 2'd0,
    MC_IF_RD  = 2'd1,
    MC_MEM_RD = 2'd2,
    MC_MEM_WR = 2'd3
  } mc_state_e;

  // An unencoded type (0) is served as a single byte.
  function automatic logic [2:0] beats_of(input logic [1:0] mw);
    case (memw_type_e'(mw))
      MW_HALF: beats_of = 3'd2;
      MW_WORD: beats_of = 3'd4;
      default: beats_of = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - fetch/data arbiter serialising word accesses onto a byte-wide RAM
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_LEN,
  parameter int RAM_ADDR_W = RAM_ADDR_LEN
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_type,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic                  mem_busy,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  mc_state_e             state;
  logic [2:0]            cnt;
  logic [2:0]            beats;
  logic [RAM_ADDR_W-1:0] base;
  logic [31:0]           wbuf;
  logic [31:0]           rbuf;
  logic [31:0]           rbuf_next;
  logic [2:0]            cnt_inc;
  logic [1:0]            lane;
  logic [RAM_ADDR_W-1:0] next_a;
  logic [7:0]            wr_byte;
  logic                  idle_ok;
  logic                  accept_mem;
  logic                  accept_if;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[ADDR_W-1:RAM_ADDR_W], mem_addr[ADDR_W-1:RAM_ADDR_W]};

  assign cnt_inc = cnt + 3'd1;
  // Byte arriving on ram_din belongs to the address issued one beat earlier.
  assign lane    = cnt[1:0] - 2'd1;
  assign next_a  = base + {{(RAM_ADDR_W-3){1'b0}}, cnt_inc};
  assign wr_byte = wbuf[{cnt_inc[1:0], 3'b000} +: 8];

  // A done cycle is never an accept cycle, so a still-held request is not re-served.
  assign idle_ok    = ~if_done & ~mem_done;
  assign accept_mem = mem_req & idle_ok;
  assign accept_if  = if_req & ~mem_req & idle_ok;

  assign mem_busy = rst_in & mem_req & ~mem_done;

  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[{lane, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= MC_IDLE;
      cnt       <= 3'd0;
      beats     <= 3'd0;
      base      <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
      if_done   <= 1'b0;
      if_data   <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      ram_a     <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      ram_wr   <= 1'b0;
      case (state)
        MC_IDLE: begin
          cnt  <= 3'd0;
          rbuf <= '0;
          if (accept_mem) begin
            base  <= mem_addr[RAM_ADDR_W-1:0];
            wbuf  <= mem_wdata;
            beats <= beats_of(mem_type);
            ram_a <= mem_addr[RAM_ADDR_W-1:0];
            if (mem_we) begin
              state    <= MC_MEM_WR;
              ram_wr   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
            end else begin
              state <= MC_MEM_RD;
            end
          end else if (accept_if) begin
            base  <= if_addr[RAM_ADDR_W-1:0];
            beats <= 3'd4;
            ram_a <= if_addr[RAM_ADDR_W-1:0];
            state <= MC_IF_RD;
          end
        end
        MC_IF_RD, MC_MEM_RD: begin
          if (state == MC_IF_RD && !if_req) begin
            state <= MC_IDLE;
          end else begin
            cnt   <= cnt_inc;
            ram_a <= next_a;
            if (cnt != 3'd0) rbuf <= rbuf_next;
            if (cnt == beats) begin
              state <= MC_IDLE;
              if (state == MC_IF_RD) begin
                if_done <= 1'b1;
                if_data <= rbuf_next;
              end else begin
                mem_done  <= 1'b1;
                mem_rdata <= rbuf_next;
              end
            end
          end
        end
        MC_MEM_WR: begin
          if (cnt_inc == beats) begin
            state    <= MC_IDLE;
            mem_done <= 1'b1;
          end else begin
            cnt      <= cnt_inc;
            ram_wr   <= 1'b1;
            ram_a    <= next_a;
            ram_dout <= wr_byte;
          end
        end
        default: state <= MC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed and randomised bench for mem_ctrl against a transaction-level model
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW       = 17;
  localparam int RAM_SIZE = 1 << AW;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic          if_done;
  logic [31:0]   if_data;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [1:0]    mem_type = '0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic          mem_done;
  logic [31:0]   mem_rdata;
  logic          mem_busy;
  logic [AW-1:0] ram_a;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  logic [7:0]    ram [RAM_SIZE];
  logic [7:0]    ref_mem [RAM_SIZE];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [7:0]    pl_d = '0;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int wr_cycles = 0;
  int if_done_cnt = 0;
  int mem_done_cnt = 0;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Byte RAM with one cycle read latency; pl_* is a bench-only preload port.
  always @(posedge clk_in) begin
    if (pl_en) ram[pl_a] <= pl_d;
    else if (ram_wr) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int beats(input logic [1:0] t);
    return (t == 2'd3) ? 4 : (t == 2'd2) ? 2 : 1;
  endfunction

  // Transaction-level model: one outstanding access, timing from accept cycle.
  bit            m_active = 1'b0;
  bit            m_port_mem, m_we;
  int            m_t0, m_n;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;
  logic [31:0]   m_if_data = '0;
  logic [31:0]   m_mem_data = '0;

  always @(negedge clk_in) begin
    bit            was_active, e_if, e_mem, e_wr;
    int            d;
    logic [AW-1:0] a;
    if (!rst_in) begin
      m_active   = 1'b0;
      m_if_data  = '0;
      m_mem_data = '0;
      chk("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
      chk("rst_flags", {29'b0, if_done, mem_done, mem_busy}, 32'd0);
      chk("rst_ram_a", {15'b0, ram_a}, 32'd0);
      chk("rst_if_data", if_data, 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
    end else begin
      e_if = 1'b0; e_mem = 1'b0; e_wr = 1'b0;
      was_active = m_active;
      if (m_active) begin
        d = cyc - m_t0;
        if (d >= 1 && d <= m_n) begin
          a = m_addr + AW'(d - 1);
          chk("ram_a", {15'b0, ram_a}, {15'b0, a});
          if (m_we) begin
            e_wr = 1'b1;
            chk("ram_dout", {24'b0, ram_dout}, {24'b0, m_wdata[8*(d-1) +: 8]});
            ref_mem[a] = m_wdata[8*(d-1) +: 8];
          end
        end
        if (m_we && d == m_n + 1) begin
          e_mem = 1'b1;
          m_active = 1'b0;
        end else if (!m_we && d == m_n + 2) begin
          if (m_port_mem) begin e_mem = 1'b1; m_mem_data = m_rdata; end
          else begin e_if = 1'b1; m_if_data = m_rdata; end
          m_active = 1'b0;
        end else if (!m_port_mem && !if_req && d <= m_n + 1) begin
          m_active = 1'b0;
        end
      end
      chk("if_done", {31'b0, if_done}, {31'b0, e_if});
      chk("mem_done", {31'b0, mem_done}, {31'b0, e_mem});
      chk("ram_wr", {31'b0, ram_wr}, {31'b0, e_wr});
      chk("if_data", if_data, m_if_data);
      chk("mem_rdata", mem_rdata, m_mem_data);
      chk("mem_busy", {31'b0, mem_busy}, {31'b0, mem_req & ~e_mem});
      if (ram_wr) wr_cycles++;
      if (if_done) if_done_cnt++;
      if (mem_done) mem_done_cnt++;
      if (!was_active && (mem_req || if_req)) begin
        m_active   = 1'b1;
        m_t0       = cyc;
        m_port_mem = mem_req;
        m_we       = mem_req & mem_we;
        m_n        = mem_req ? beats(mem_type) : 4;
        m_addr     = mem_req ? mem_addr[AW-1:0] : if_addr[AW-1:0];
        m_wdata    = mem_wdata;
        m_rdata    = '0;
        for (int k = 0; k < m_n; k++) m_rdata[8*k +: 8] = ref_mem[m_addr + AW'(k)];
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pl(input int a, input logic [7:0] dv);
    pl_en = 1'b1;
    pl_a  = AW'(a);
    pl_d  = dv;
    ref_mem[AW'(a)] = dv;
    step();
    pl_en = 1'b0;
  endtask

  task automatic wait_done(input bit port_mem, input int t0, output int lat, output logic [31:0] dv);
    lat = -1;
    dv  = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (port_mem ? mem_done : if_done) begin
        lat = cyc - t0;
        dv  = port_mem ? mem_rdata : if_data;
        break;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0]   hi = $urandom;
    logic [AW-1:0] lo;
    case ($urandom_range(0, 2))
      0:       lo = AW'($urandom_range(0, 'h3FF));
      1:       lo = AW'($urandom_range('h1FF00, 'h1FFFF));
      default: lo = AW'($urandom_range(0, 15));
    endcase
    return {hi[31:AW], lo};
  endfunction

  task automatic rand_mem();
    mem_we    = 1'($urandom_range(0, 1));
    mem_type  = 2'($urandom_range(0, 3));
    mem_addr  = rand_addr();
    mem_wdata = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, t0;
    logic [31:0] dv;
    bit          prev_md, prev_id;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;

    for (int i = 0; i < 'h410; i++) pl(i, 8'($urandom));
    for (int i = 'h1FF00; i < RAM_SIZE; i++) pl(i, 8'($urandom));
    pl('h100, 8'h13); pl('h101, 8'h05); pl('h102, 8'h00); pl('h103, 8'h00);
    pl('h0, 8'h93); pl('h1, 8'h00); pl('h2, 8'h00); pl('h3, 8'h00);
    pl('h10, 8'h80);

    // Fetch of a known instruction
    step(); if_req = 1'b1; if_addr = 32'h100; t0 = cyc; wr_cycles = 0;
    wait_done(1'b0, t0, lat, dv);
    chk("t1_latency", lat, 32'd6);
    chk("t1_if_data", dv, 32'h00000513);
    chk("t1_no_write", wr_cycles, 32'd0);
    step(); if_req = 1'b0;

    // Word write
    step(); mem_req = 1'b1; mem_we = 1'b1; mem_type = MW_WORD; mem_addr = 32'h200;
    mem_wdata = 32'hDEADBEEF; t0 = cyc; wr_cycles = 0;
    wait_done(1'b1, t0, lat, dv);
    chk("t2_latency", lat, 32'd5);
    chk("t2_wr_cycles", wr_cycles, 32'd4);
    chk("t2_ram_bytes", {ram['h203], ram['h202], ram['h201], ram['h200]}, 32'hDEADBEEF);
    step(); mem_req = 1'b0; mem_we = 1'b0;

    // Simultaneous requests: data port first
    step(); if_req = 1'b1; if_addr = 32'h0; mem_req = 1'b1; mem_we = 1'b0;
    mem_type = MW_BYTE; mem_addr = 32'h10; t0 = cyc;
    wait_done(1'b1, t0, lat, dv);
    chk("t3_mem_latency", lat, 32'd3);
    chk("t3_mem_rdata", dv, 32'h00000080);
    step(); mem_req = 1'b0;
    wait_done(1'b0, t0, lat, dv);
    chk("t3_if_latency", lat, 32'd10);
    chk("t3_if_data", dv, 32'h00000093);
    step(); if_req = 1'b0;

    // Fetch aborted at T+2 with a data read queued behind it
    step(); if_req = 1'b1; if_addr = 32'h100; t0 = cyc; if_done_cnt = 0;
    step(); mem_req = 1'b1; mem_we = 1'b0; mem_type = MW_WORD; mem_addr = 32'h200;
    step(); if_req = 1'b0;
    wait_done(1'b1, t0, lat, dv);
    chk("t4_mem_latency", lat, 32'd9);
    chk("t4_mem_rdata", dv, 32'hDEADBEEF);
    chk("t4_no_if_done", if_done_cnt, 32'd0);
    step(); mem_req = 1'b0;

    // Half write wrapping past the top of RAM
    step(); mem_req = 1'b1; mem_we = 1'b1; mem_type = MW_HALF; mem_addr = 32'h0003FFFF;
    mem_wdata = 32'h5555ABCD; t0 = cyc;
    wait_done(1'b1, t0, lat, dv);
    chk("t5_latency", lat, 32'd3);
    chk("t5_top_byte", {24'b0, ram['h1FFFF]}, 32'hCD);
    chk("t5_wrap_byte", {24'b0, ram['h0]}, 32'hAB);
    step(); mem_req = 1'b0; mem_we = 1'b0;

    // Reset in the middle of a word write
    step(); mem_req = 1'b1; mem_we = 1'b1; mem_type = MW_WORD; mem_addr = 32'h300;
    mem_wdata = 32'h11223344;
    step(); step();
    rst_in = 1'b0;
    #1;
    chk("t6_ram_wr", {31'b0, ram_wr}, 32'd0);
    chk("t6_flags", {29'b0, if_done, mem_done, mem_busy}, 32'd0);
    chk("t6_ram_a", {15'b0, ram_a}, 32'd0);
    chk("t6_ram_dout", {24'b0, ram_dout}, 32'd0);
    chk("t6_mem_rdata", mem_rdata, 32'd0);
    chk("t6_first_beat", {24'b0, ram['h300]}, 32'h44);
    mem_req = 1'b0; mem_we = 1'b0;
    step(); step();
    rst_in = 1'b1; mem_done_cnt = 0; if_done_cnt = 0;
    repeat (5) step();
    chk("t6_no_spurious_done", mem_done_cnt + if_done_cnt, 32'd0);

    // Randomised traffic
    prev_md = 1'b0; prev_id = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if ($urandom_range(0, 599) == 0) begin
        rst_in = 1'b0; if_req = 1'b0; mem_req = 1'b0;
        step();
        rst_in = 1'b1; prev_md = 1'b0; prev_id = 1'b0;
        continue;
      end
      if (mem_req) begin
        if (prev_md) begin
          mem_req = ($urandom_range(0, 2) == 0);
          if (mem_req) rand_mem();
        end else if (!mem_done && $urandom_range(0, 7) == 0) begin
          rand_mem();
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mem_req = 1'b1;
        rand_mem();
      end
      prev_md = mem_done;
      if (if_req) begin
        if (prev_id) begin
          if_req  = ($urandom_range(0, 2) == 0);
          if_addr = rand_addr();
        end else if (!if_done && $urandom_range(0, 19) == 0) begin
          if_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = rand_addr();
      end
      prev_id = if_done;
    end
    step(); if_req = 1'b0; mem_req = 1'b0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
